// File: rtl/morse_decoder_if.sv
// rtl/morse_decoder_if.sv - Morse line in, decoded letter/status out
interface morse_decoder_if;
    logic       DotDashIn;
    logic [2:0] Letter;
    logic       LetterValid;
    logic       Error;
    logic       Busy;

    modport master (
        output DotDashIn,
        input  Letter,
        input  LetterValid,
        input  Error,
        input  Busy
    );

    modport slave (
        input  DotDashIn,
        output Letter,
        output LetterValid,
        output Error,
        output Busy
    );
endinterface

// File: rtl/morse_decoder.sv
// rtl/morse_decoder.sv - tick-sampled Morse decoder for letters A..H
// Define MORSE_DECODER_ERR_EN to enable Error pulses and the RECOVER state.
module morse_decoder #(
    parameter int TICK_DIV = 250,
    parameter int MAX_MARK = 4
) (
    input  logic             ClockIn,
    input  logic             Reset,
    morse_decoder_if.slave   bus
);

    localparam int DIV_W  = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam int MARK_W = $clog2(MAX_MARK + 1);

`ifdef MORSE_DECODER_ERR_EN
    typedef enum logic [1:0] {IDLE, MARK, SPACE, RECOVER} state_t;
`else
    typedef enum logic [1:0] {IDLE, MARK, SPACE} state_t;
`endif

    state_t              state;
    logic [DIV_W-1:0]    tick_cnt;
    logic                tick;
    logic [MARK_W-1:0]   markcnt;
    logic [1:0]          spacecnt;
    logic [2:0]          elemcnt;
    logic [3:0]          pattern;
    logic [3:0]          dec;

`ifdef MORSE_DECODER_ERR_EN
    logic error_q;
    assign bus.Error = error_q;
`else
    logic drop;
    assign bus.Error = 1'b0;
`endif

    // Pattern bit i holds element i (first element in bit 0), 1 = dash.
    function automatic logic [3:0] decode(input logic [2:0] len, input logic [3:0] pat);
        case ({len, pat})
            7'b010_0010: decode = {1'b1, 3'd0};
            7'b100_0001: decode = {1'b1, 3'd1};
            7'b100_0101: decode = {1'b1, 3'd2};
            7'b011_0001: decode = {1'b1, 3'd3};
            7'b001_0000: decode = {1'b1, 3'd4};
            7'b100_0100: decode = {1'b1, 3'd5};
            7'b011_0011: decode = {1'b1, 3'd6};
            7'b100_0000: decode = {1'b1, 3'd7};
            default:     decode = 4'b0000;
        endcase
    endfunction

    assign dec  = decode(elemcnt, pattern);
    assign tick = (tick_cnt == DIV_W'(TICK_DIV - 1));

    always_ff @(posedge ClockIn or negedge Reset) begin
        if (!Reset)
            tick_cnt <= '0;
        else if (tick)
            tick_cnt <= '0;
        else
            tick_cnt <= tick_cnt + 1'b1;
    end

    always_ff @(posedge ClockIn or negedge Reset) begin
        if (!Reset) begin
            state           <= IDLE;
            markcnt         <= '0;
            spacecnt        <= '0;
            elemcnt         <= '0;
            pattern         <= '0;
            bus.Letter      <= '0;
            bus.LetterValid <= 1'b0;
            bus.Busy        <= 1'b0;
`ifdef MORSE_DECODER_ERR_EN
            error_q         <= 1'b0;
`else
            drop            <= 1'b0;
`endif
        end else begin
            bus.LetterValid <= 1'b0;
`ifdef MORSE_DECODER_ERR_EN
            error_q         <= 1'b0;
`endif
            if (tick) begin
                case (state)
                    IDLE: begin
                        if (bus.DotDashIn) begin
                            state    <= MARK;
                            markcnt  <= MARK_W'(1);
                            elemcnt  <= '0;
                            pattern  <= '0;
                            bus.Busy <= 1'b1;
`ifndef MORSE_DECODER_ERR_EN
                            drop     <= 1'b0;
`endif
                        end
                    end
                    MARK: begin
                        if (bus.DotDashIn) begin
`ifdef MORSE_DECODER_ERR_EN
                            if (markcnt >= MARK_W'(MAX_MARK - 1)) begin
                                error_q  <= 1'b1;
                                state    <= RECOVER;
                                spacecnt <= '0;
                            end else begin
                                markcnt <= markcnt + 1'b1;
                            end
`else
                            // Overlong mark: remember it and drain until 3 quiet ticks.
                            if (markcnt != MARK_W'(MAX_MARK))
                                markcnt <= markcnt + 1'b1;
                            if (markcnt >= MARK_W'(MAX_MARK - 1))
                                drop <= 1'b1;
`endif
                        end else begin
`ifndef MORSE_DECODER_ERR_EN
                            if (drop) begin
                                state    <= SPACE;
                                spacecnt <= 2'd1;
                            end else
`endif
                            if (elemcnt == 3'd4) begin
`ifdef MORSE_DECODER_ERR_EN
                                error_q  <= 1'b1;
                                state    <= RECOVER;
                                spacecnt <= '0;
`else
                                state    <= IDLE;
                                bus.Busy <= 1'b0;
`endif
                            end else begin
                                pattern[elemcnt[1:0]] <= (markcnt >= MARK_W'(2));
                                elemcnt  <= elemcnt + 1'b1;
                                state    <= SPACE;
                                spacecnt <= 2'd1;
                            end
                        end
                    end
                    SPACE: begin
                        if (bus.DotDashIn) begin
                            state   <= MARK;
                            markcnt <= MARK_W'(1);
                        end else if (spacecnt == 2'd2) begin
                            spacecnt <= 2'd3;
                            state    <= IDLE;
                            bus.Busy <= 1'b0;
`ifdef MORSE_DECODER_ERR_EN
                            if (dec[3]) begin
                                bus.Letter      <= dec[2:0];
                                bus.LetterValid <= 1'b1;
                            end else begin
                                error_q <= 1'b1;
                            end
`else
                            if (dec[3] && !drop) begin
                                bus.Letter      <= dec[2:0];
                                bus.LetterValid <= 1'b1;
                            end
`endif
                        end else begin
                            spacecnt <= spacecnt + 1'b1;
                        end
                    end
`ifdef MORSE_DECODER_ERR_EN
                    RECOVER: begin
                        if (bus.DotDashIn) begin
                            spacecnt <= '0;
                        end else if (spacecnt == 2'd2) begin
                            spacecnt <= 2'd3;
                            state    <= IDLE;
                            bus.Busy <= 1'b0;
                        end else begin
                            spacecnt <= spacecnt + 1'b1;
                        end
                    end
`endif
                    default: begin
                        state    <= IDLE;
                        bus.Busy <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_morse_decoder.sv
// tb/tb_morse_decoder.sv - directed self-checking bench for morse_decoder
module tb_morse_decoder;

    localparam int TD = 4;

    logic clk_in = 1'b0;
    logic reset  = 1'b0;

    morse_decoder_if bus();

    morse_decoder #(.TICK_DIV(TD), .MAX_MARK(4)) dut (
        .ClockIn (clk_in),
        .Reset   (reset),
        .bus     (bus)
    );

    always #5 clk_in = ~clk_in;

    int checks     = 0;
    int errors     = 0;
    int lv_count   = 0;
    int err_count  = 0;
    int both_count = 0;
    int lv0, er0;

    always @(negedge clk_in) begin
        if (bus.LetterValid) lv_count++;
        if (bus.Error) err_count++;
        if (bus.LetterValid && bus.Error) both_count++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input logic v);
        bus.DotDashIn = v;
        repeat (TD) @(posedge clk_in);
        #1;
    endtask

    task automatic send(input logic [15:0] bits, input int n);
        for (int i = n - 1; i >= 0; i--) tick(bits[i]);
        @(negedge clk_in);
        #1;
    endtask

    task automatic letter(input string tag, input logic [15:0] bits, input int n, input logic [2:0] exp);
        lv0 = lv_count;
        er0 = err_count;
        send(bits, n);
        @(negedge clk_in);
        #1;
        check({tag, "_letter"}, 32'(bus.Letter), 32'(exp));
        check({tag, "_lv_pulses"}, lv_count - lv0, 1);
        check({tag, "_err_pulses"}, err_count - er0, 0);
        check({tag, "_busy"}, 32'(bus.Busy), 0);
    endtask

    initial begin
        bus.DotDashIn = 1'b0;
        repeat (3) @(negedge clk_in);
        #1;
        check("rst_letter", 32'(bus.Letter), 0);
        check("rst_lv", 32'(bus.LetterValid), 0);
        check("rst_err", 32'(bus.Error), 0);
        check("rst_busy", 32'(bus.Busy), 0);
        reset = 1'b1;

        letter("A", 16'b10111000, 8, 3'd0);
        letter("B", 16'b111010101000, 12, 3'd1);
        letter("H", 16'b1010101000, 10, 3'd7);

        // five dots, then one extra quiet tick
        lv0 = lv_count;
        er0 = err_count;
        tick(1'b1);
        check("dots_busy_mid", 32'(bus.Busy), 1);
        send(16'b01010101000, 11);
        send(16'b0, 1);
        check("dots_lv", lv_count - lv0, 0);
        check("dots_letter", 32'(bus.Letter), 7);
        check("dots_busy", 32'(bus.Busy), 0);
`ifdef MORSE_DECODER_ERR_EN
        check("dots_err", err_count - er0, 1);
`else
        check("dots_err", err_count - er0, 0);
`endif

        letter("C", 16'b110101101000, 12, 3'd2);
        letter("D", 16'b110101000, 9, 3'd3);
        letter("F", 16'b10101101000, 11, 3'd5);
        letter("G", 16'b1101101000, 10, 3'd6);

        // overlong mark: six 1 ticks
        lv0 = lv_count;
        er0 = err_count;
        tick(1'b1); tick(1'b1); tick(1'b1);
        check("long_err_t3", 32'(bus.Error), 0);
        tick(1'b1);
`ifdef MORSE_DECODER_ERR_EN
        check("long_err_t4", 32'(bus.Error), 1);
`else
        check("long_err_t4", 32'(bus.Error), 0);
`endif
        tick(1'b1); tick(1'b1);
        tick(1'b0); tick(1'b0);
        check("long_busy_2z", 32'(bus.Busy), 1);
        tick(1'b0);
        check("long_busy_3z", 32'(bus.Busy), 0);
        @(negedge clk_in);
        #1;
        check("long_lv", lv_count - lv0, 0);
        check("long_letter", 32'(bus.Letter), 6);
`ifdef MORSE_DECODER_ERR_EN
        check("long_err_count", err_count - er0, 1);
`else
        check("long_err_count", err_count - er0, 0);
`endif
        letter("E", 16'b1000, 4, 3'd4);

        // reset in the middle of G
        letter("B2", 16'b111010101000, 12, 3'd1);
        tick(1'b1); tick(1'b1); tick(1'b0); tick(1'b1);
        check("midrst_busy_before", 32'(bus.Busy), 1);
        @(negedge clk_in);
        reset = 1'b0;
        #1;
        check("midrst_letter", 32'(bus.Letter), 0);
        check("midrst_lv", 32'(bus.LetterValid), 0);
        check("midrst_err", 32'(bus.Error), 0);
        check("midrst_busy", 32'(bus.Busy), 0);
        bus.DotDashIn = 1'b0;
        @(negedge clk_in);
        reset = 1'b1;
        lv0 = lv_count;
        er0 = err_count;
        send(16'b0, 5);
        check("midrst_no_lv", lv_count - lv0, 0);
        check("midrst_no_err", err_count - er0, 0);
        check("midrst_idle", 32'(bus.Busy), 0);
        letter("E2", 16'b1000, 4, 3'd4);

        // repeating transmitter output: three back-to-back A
        lv0 = lv_count;
        send(16'b10111000, 8);
        send(16'b10111000, 8);
        send(16'b10111000, 8);
        @(negedge clk_in);
        #1;
        check("repeat_lv", lv_count - lv0, 3);
        check("repeat_letter", 32'(bus.Letter), 0);

        check("lv_err_overlap", both_count, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/morse_decoder.md
MORSE_DECODER -- requirements
Module: morse_decoder

Interface
REQ-001 SHALL have parameter TICK_DIV, default 250; ClockIn cycles per symbol-sample tick, minimum 2.
REQ-002 SHALL have parameter MAX_MARK, default 4; mark length in ticks that is declared an error.
REQ-003 SHALL have port ClockIn  input  1  system clock; all state changes on its rising edge.
REQ-004 SHALL have port Reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port DotDashIn  input  1  serial Morse line, same clock domain as ClockIn, 1 = mark.
REQ-006 SHALL have port Letter  output  3  decoded letter index: A=0 B=1 C=2 D=3 E=4 F=5 G=6 H=7.
REQ-007 SHALL have port LetterValid  output  1  one-cycle pulse; Letter is updated on the same edge.
REQ-008 SHALL have port Error  output  1  one-cycle pulse on a malformed or unrecognised symbol.
REQ-009 SHALL have port Busy  output  1  high when the FSM is in any state other than IDLE.

Function
REQ-010 SHALL contain a tick counter that pulses an internal tick once every TICK_DIV ClockIn cycles, free-running from reset release.
REQ-011 SHALL sample DotDashIn only on tick cycles; all mark and space lengths are counted in ticks.
REQ-012 SHALL implement FSM states IDLE, MARK, SPACE and RECOVER; the reset state is IDLE.
REQ-013 IDLE: tick with sample 1 -> MARK with markcnt=1, elemcnt=0, pattern cleared; sample 0 -> stay in IDLE.
REQ-014 MARK: tick with sample 1 -> markcnt+1; on reaching MAX_MARK -> Error pulse, go to RECOVER.
REQ-015 MARK: tick with sample 0 -> store an element (markcnt==1 gives dot=0, markcnt>=2 gives dash=1), elemcnt+1, go to SPACE with spacecnt=1.
REQ-016 Storing a fifth element SHALL raise an Error pulse and go to RECOVER.
REQ-017 SPACE: tick with sample 1 and spacecnt<3 -> MARK with markcnt=1 (intra-letter gap).
REQ-018 SPACE: tick with sample 0 -> spacecnt+1; when spacecnt reaches 3 -> decode the letter and go to IDLE.
REQ-019 Decode table, first element first: A .-  B -...  C -.-.  D -..  E .  F ..-.  G --.  H ....
REQ-020 A match SHALL load Letter and pulse LetterValid for exactly one cycle, on the ClockIn edge after the deciding tick.
REQ-021 A pattern not in the table SHALL pulse Error instead, and Letter SHALL be left unchanged.
REQ-022 RECOVER SHALL wait for 3 consecutive 0 samples, then return to IDLE; a 1 sample restarts that count.
REQ-023 Letter SHALL hold its value between LetterValid pulses.
REQ-024 LetterValid and Error SHALL never be asserted in the same cycle.
REQ-025 A repeating stream of one letter (the rotating transmitter output) SHALL produce one LetterValid per repetition.
REQ-026 markcnt SHALL saturate and never wrap; spacecnt SHALL saturate at 3.

Reset
REQ-027 Reset low SHALL immediately force: FSM=IDLE, all counters=0, Letter=0, LetterValid=0, Error=0, Busy=0.
REQ-028 Reset asserted mid-letter SHALL discard the partial pattern, with no LetterValid or Error pulse afterwards.
REQ-029 The first tick SHALL occur TICK_DIV cycles after Reset is released.

Configuration
REQ-030 Macro MORSE_DECODER_ERR_EN defined SHALL enable Error detection and the RECOVER state exactly as in REQ-014, REQ-016, REQ-021 and REQ-022.
REQ-031 Without MORSE_DECODER_ERR_EN, Error SHALL be tied to 0 and RECOVER SHALL not exist.
REQ-032 Without MORSE_DECODER_ERR_EN, malformed or unrecognised symbols SHALL be dropped silently with a direct return to IDLE (overlong marks after 3 consecutive 0 samples); the port list SHALL not change.

Verification (TICK_DIV=4, MAX_MARK=4, macro defined unless stated)
REQ-033 Ticks 1,0,1,1,1,0,0,0 (A) -> LetterValid single pulse, Letter=0, Error=0.
REQ-034 Ticks 1,1,1,0,1,0,1,0,1,0,0,0 (B) -> Letter=1; ticks 1,0,1,0,1,0,1,0,0,0 (H) -> Letter=7.
REQ-035 Ticks 1,0,1,0,1,0,1,0,1,0,0,0 (five dots) -> Error pulse, no LetterValid, Letter unchanged.
REQ-036 Line held 1 for 6 ticks -> Error on the 4th mark tick; no LetterValid until 3 consecutive 0 ticks, then a following E (1,0,0,0) decodes to Letter=4.
REQ-037 Reset pulsed low midway through G (--.) -> all outputs 0 immediately; no pulse follows; the next complete E decodes to Letter=4.
REQ-038 Macro undefined, five dots sent -> Error stays 0, no LetterValid, Busy returns to 0.
